// File: rtl/scarv_cop_common.sv
// Shared constants for the ISE coprocessor dispatch logic: instruction
// class codes, return error codes, dispatch FSM encodings and the mapping
// from instruction class to FU issue lane.
package scarv_cop_common;

    // Instruction classes reported by the decoder (0 means "no class").
    localparam logic [2:0] ICLASS_NONE         = 3'd0;
    localparam logic [2:0] ICLASS_PACKED_ARITH = 3'd1;
    localparam logic [2:0] ICLASS_TWIDDLE      = 3'd2;
    localparam logic [2:0] ICLASS_LOADSTORE    = 3'd3;
    localparam logic [2:0] ICLASS_RANDOM       = 3'd4;
    localparam logic [2:0] ICLASS_MOVE         = 3'd5;
    localparam logic [2:0] ICLASS_MP           = 3'd6;
    localparam logic [2:0] ICLASS_BITWISE      = 3'd7;

    // Error codes returned to the CPU alongside each result.
    localparam logic [1:0] RTN_OK      = 2'b00;
    localparam logic [1:0] RTN_ILLEGAL = 2'b01;
    localparam logic [1:0] RTN_TIMEOUT = 2'b10;

    // Dispatch FSM state encodings.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_RESPOND = 2'd3;

    // One-hot FU issue lane for a non-zero class: lane index is class-1.
    function automatic logic [6:0] fu_lane(input logic [2:0] cls);
        logic [6:0] one_s;
        one_s = 7'b000_0001;
        return one_s << (cls - 3'd1);
    endfunction

endpackage

// File: rtl/scarv_cop_dispatch_timer.sv
// FU watchdog counter: cleared when an instruction is issued, advanced on
// every waiting cycle, and flags expiry when it reaches LIMIT.
module scarv_cop_dispatch_timer #(
    parameter logic [7:0] LIMIT = 8'd63
) (
    input  logic g_clk,
    input  logic g_resetn,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Next count: clear has priority over advance, otherwise hold.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = 8'd0;
        end else if (en_i) begin
            count_d = count_q + 8'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LIMIT);

endmodule

// File: rtl/scarv_cop_dispatch.sv
// Coprocessor dispatch controller: accepts one instruction from the CPU,
// presents it to the decoder, issues it to the FU selected by its class,
// waits for completion (or a timeout) and returns the result to the CPU.
module scarv_cop_dispatch
    import scarv_cop_common::*;
#(
    parameter int unsigned FU_TIMEOUT = 64,
    parameter int unsigned NUM_FU     = 7
) (
    input  logic              g_clk,
    input  logic              g_resetn,
    input  logic              cpu_insn_req,
    output logic              cpu_insn_ack,
    input  logic [31:0]       cpu_insn_enc,
    output logic              cpu_rtn_valid,
    input  logic              cpu_rtn_ack,
    output logic [1:0]        cpu_rtn_err,
    output logic [4:0]        cpu_rtn_rd,
    output logic [31:0]       cpu_rtn_data,
    output logic              cpu_rtn_wen,
    output logic [31:0]       id_encoded,
    input  logic              id_exception,
    input  logic [2:0]        id_class,
    input  logic [4:0]        id_rd,
    output logic [NUM_FU-1:0] fu_ivalid,
    input  logic [NUM_FU-1:0] fu_idone,
    input  logic              fu_gpr_wen,
    input  logic [31:0]       fu_gpr_wdata
);

    logic [1:0]        state_q,     state_d;
    logic [31:0]       insn_q,      insn_d;
    logic [4:0]        rd_q,        rd_d;
    logic [NUM_FU-1:0] fu_ivalid_q, fu_ivalid_d;
    logic              insn_ack_q,  insn_ack_d;
    logic              rtn_valid_q, rtn_valid_d;
    logic [1:0]        rtn_err_q,   rtn_err_d;
    logic [4:0]        rtn_rd_q,    rtn_rd_d;
    logic [31:0]       rtn_data_q,  rtn_data_d;
    logic              rtn_wen_q,   rtn_wen_d;
    logic              tmr_clr_s;
    logic              tmr_en_s;
    logic              tmr_expired_s;
    logic              done_s;

    // Only the completion bit of the lane that was actually issued counts.
    assign done_s = |(fu_idone & fu_ivalid_q);

    scarv_cop_dispatch_timer #(
        .LIMIT (8'(FU_TIMEOUT - 1))
    ) u_timer (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .clr_i     (tmr_clr_s),
        .en_i      (tmr_en_s),
        .expired_o (tmr_expired_s)
    );

    // Dispatch sequencing: next state, issue lane and response fields.
    always_comb begin
        state_d     = state_q;
        insn_d      = insn_q;
        rd_d        = rd_q;
        fu_ivalid_d = fu_ivalid_q;
        rtn_err_d   = rtn_err_q;
        rtn_rd_d    = rtn_rd_q;
        rtn_data_d  = rtn_data_q;
        rtn_wen_d   = rtn_wen_q;
        tmr_clr_s   = 1'b0;
        tmr_en_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cpu_insn_req) begin
                    insn_d  = cpu_insn_enc;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (id_exception || (id_class == ICLASS_NONE)) begin
                    rtn_err_d  = RTN_ILLEGAL;
                    rtn_wen_d  = 1'b0;
                    rtn_data_d = 32'd0;
                    rtn_rd_d   = id_rd;
                    state_d    = ST_RESPOND;
                end else begin
                    rd_d        = id_rd;
                    fu_ivalid_d = fu_lane(id_class);
                    tmr_clr_s   = 1'b1;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A completion on the final cycle beats the timeout.
                if (done_s) begin
                    fu_ivalid_d = '0;
                    rtn_err_d   = RTN_OK;
                    rtn_wen_d   = fu_gpr_wen;
                    rtn_data_d  = fu_gpr_wen ? fu_gpr_wdata : 32'd0;
                    rtn_rd_d    = rd_q;
                    state_d     = ST_RESPOND;
                end else if (tmr_expired_s) begin
                    fu_ivalid_d = '0;
                    rtn_err_d   = RTN_TIMEOUT;
                    rtn_wen_d   = 1'b0;
                    rtn_data_d  = 32'd0;
                    rtn_rd_d    = rd_q;
                    state_d     = ST_RESPOND;
                end else begin
                    tmr_en_s = 1'b1;
                end
            end
            ST_RESPOND: begin
                if (cpu_rtn_ack) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESPOND;
                end
            end
            default: begin
                fu_ivalid_d = '0;
                state_d     = ST_IDLE;
            end
        endcase
        insn_ack_d  = (state_d == ST_IDLE);
        rtn_valid_d = (state_d == ST_RESPOND);
    end

    // Dispatch registers; every CPU/FU-facing output comes straight from here.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q     <= ST_IDLE;
            insn_q      <= 32'd0;
            rd_q        <= 5'd0;
            fu_ivalid_q <= '0;
            insn_ack_q  <= 1'b1;
            rtn_valid_q <= 1'b0;
            rtn_err_q   <= RTN_OK;
            rtn_rd_q    <= 5'd0;
            rtn_data_q  <= 32'd0;
            rtn_wen_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            insn_q      <= insn_d;
            rd_q        <= rd_d;
            fu_ivalid_q <= fu_ivalid_d;
            insn_ack_q  <= insn_ack_d;
            rtn_valid_q <= rtn_valid_d;
            rtn_err_q   <= rtn_err_d;
            rtn_rd_q    <= rtn_rd_d;
            rtn_data_q  <= rtn_data_d;
            rtn_wen_q   <= rtn_wen_d;
        end
    end

    assign cpu_insn_ack  = insn_ack_q;
    assign cpu_rtn_valid = rtn_valid_q;
    assign cpu_rtn_err   = rtn_err_q;
    assign cpu_rtn_rd    = rtn_rd_q;
    assign cpu_rtn_data  = rtn_data_q;
    assign cpu_rtn_wen   = rtn_wen_q;
    assign id_encoded    = insn_q;
    assign fu_ivalid     = fu_ivalid_q;

endmodule

// File: tb/tb_scarv_cop_dispatch.sv
// Self-checking bench for scarv_cop_dispatch. A transaction-level model
// turns each instruction's description (class, legality, FU completion lag,
// response hold time) into a timeline of expected outputs indexed by the
// number of clock edges since the request was accepted.
module tb_scarv_cop_dispatch;

    localparam int T = 8;

    logic        g_clk = 1'b0;
    logic        g_resetn;
    logic        cpu_insn_req;
    logic        cpu_insn_ack;
    logic [31:0] cpu_insn_enc;
    logic        cpu_rtn_valid;
    logic        cpu_rtn_ack;
    logic [1:0]  cpu_rtn_err;
    logic [4:0]  cpu_rtn_rd;
    logic [31:0] cpu_rtn_data;
    logic        cpu_rtn_wen;
    logic [31:0] id_encoded;
    logic        id_exception;
    logic [2:0]  id_class;
    logic [4:0]  id_rd;
    logic [6:0]  fu_ivalid;
    logic [6:0]  fu_idone;
    logic        fu_gpr_wen;
    logic [31:0] fu_gpr_wdata;

    scarv_cop_dispatch #(.FU_TIMEOUT(T), .NUM_FU(7)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .cpu_insn_req(cpu_insn_req), .cpu_insn_ack(cpu_insn_ack), .cpu_insn_enc(cpu_insn_enc),
        .cpu_rtn_valid(cpu_rtn_valid), .cpu_rtn_ack(cpu_rtn_ack), .cpu_rtn_err(cpu_rtn_err),
        .cpu_rtn_rd(cpu_rtn_rd), .cpu_rtn_data(cpu_rtn_data), .cpu_rtn_wen(cpu_rtn_wen),
        .id_encoded(id_encoded), .id_exception(id_exception), .id_class(id_class), .id_rd(id_rd),
        .fu_ivalid(fu_ivalid), .fu_idone(fu_idone), .fu_gpr_wen(fu_gpr_wen), .fu_gpr_wdata(fu_gpr_wdata)
    );

    always #5 g_clk = ~g_clk;

    // Toy decoder: class in [2:0], illegal flag in [3], destination in [8:4].
    assign id_class     = id_encoded[2:0];
    assign id_exception = id_encoded[3];
    assign id_rd        = id_encoded[8:4];

    int vecs = 0;
    int miss = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Current transaction description and model timeline.
    bit          chk_en = 1'b0;
    bit          t_active = 1'b0;
    logic [31:0] t_enc;
    logic [2:0]  t_cls;
    logic [4:0]  t_rd;
    logic [31:0] t_wdata;
    bit          t_legal, t_to, t_wen, t_tie;
    int          t_d, t_L, t_resp, t_end, t_hold;
    int          n = 0;
    int          iv_cnt, first_v;
    logic [1:0]  cap_err;
    logic [4:0]  cap_rd;
    logic [31:0] cap_data;
    logic        cap_wen;

    // Compare process: every cycle, DUT outputs against the model timeline.
    always @(posedge g_clk) begin
        logic        e_ack, e_valid, ok;
        logic [6:0]  e_iv;
        logic [31:0] e_enc;
        logic [1:0]  e_err;
        #1;
        if (chk_en) begin
            if (t_active) n = n + 1;
            e_ack = 1'b1; e_valid = 1'b0; e_iv = 7'd0; e_enc = 32'd0;
            if (t_active) begin
                e_enc   = t_enc;
                e_ack   = (n >= t_end);
                if (t_legal && n >= 2 && n <= 1 + t_L) e_iv[t_cls - 3'd1] = 1'b1;
                e_valid = (n >= t_resp && n < t_end);
                if (fu_ivalid != 7'd0) iv_cnt++;
                if (cpu_rtn_valid && first_v == 0) first_v = n;
            end
            chk("insn_ack",   {31'd0, cpu_insn_ack},  {31'd0, e_ack});
            chk("id_encoded", id_encoded,             e_enc);
            chk("fu_ivalid",  {25'd0, fu_ivalid},     {25'd0, e_iv});
            chk("rtn_valid",  {31'd0, cpu_rtn_valid}, {31'd0, e_valid});
            if (e_valid && cpu_rtn_valid) begin
                e_err = !t_legal ? 2'b01 : (t_to ? 2'b10 : 2'b00);
                ok    = t_legal && !t_to;
                chk("rtn_err",  {30'd0, cpu_rtn_err}, {30'd0, e_err});
                chk("rtn_wen",  {31'd0, cpu_rtn_wen}, {31'd0, ok && t_wen});
                chk("rtn_data", cpu_rtn_data, (ok && t_wen) ? t_wdata : 32'd0);
                if (e_err != 2'b10) chk("rtn_rd", {27'd0, cpu_rtn_rd}, {27'd0, t_rd});
                cap_err = cpu_rtn_err; cap_rd = cpu_rtn_rd;
                cap_data = cpu_rtn_data; cap_wen = cpu_rtn_wen;
            end
        end
    end

    // Load a transaction into the model and present the request (called at a negedge).
    task automatic start_txn(input logic [2:0] cls, input logic exc, input logic [4:0] rd,
                             input int d, input logic wen, input logic [31:0] wdata,
                             input int hold, input bit tie);
        logic [31:0] r;
        r       = $urandom();
        t_cls   = cls; t_rd = rd; t_d = d; t_wen = wen; t_wdata = wdata;
        t_hold  = hold; t_tie = tie;
        t_enc   = {r[31:9], rd, exc, cls};
        t_legal = !exc && (cls != 3'd0);
        t_to    = !(d != 0 && d <= T);
        t_L     = t_to ? T : d;
        t_resp  = t_legal ? 2 + t_L : 2;
        t_end   = t_resp + hold + 1;
        iv_cnt = 0; first_v = 0; n = 0; t_active = 1'b1;
        cpu_insn_enc = t_enc; cpu_insn_req = 1'b1;
        cpu_rtn_ack = tie; fu_gpr_wen = wen; fu_gpr_wdata = wdata;
    endtask

    // Drive the FU and CPU sides for one transaction until it has retired.
    task automatic run_txn(input logic [2:0] cls, input logic exc, input logic [4:0] rd,
                           input int d, input logic wen, input logic [31:0] wdata,
                           input int hold, input bit tie, input bit noise, input bit wrong);
        int guard;
        guard = 0;
        start_txn(cls, exc, rd, d, wen, wdata, hold, tie);
        while (1) begin
            @(negedge g_clk);
            guard++;
            if (n >= t_end || guard > 500) break;
            cpu_insn_req = noise;
            if (noise) cpu_insn_enc = $urandom();
            fu_idone = 7'd0;
            if (t_legal && t_d != 0 && n == t_d + 1) fu_idone[t_cls - 3'd1] = 1'b1;
            if (wrong && t_legal && n == 2) fu_idone[t_cls % 7] = 1'b1;
            cpu_rtn_ack = t_tie || (n >= t_resp + t_hold);
        end
        if (guard > 500) begin
            vecs++; miss++;
            $display("FAIL txn_bound: transaction did not retire within %0d cycles", guard);
        end
        cpu_insn_req = 1'b0; fu_idone = 7'd0; cpu_rtn_ack = 1'b0;
    endtask

    initial begin
        g_resetn = 1'b0; cpu_insn_req = 1'b0; cpu_insn_enc = 32'd0; cpu_rtn_ack = 1'b0;
        fu_idone = 7'd0; fu_gpr_wen = 1'b0; fu_gpr_wdata = 32'd0;
        repeat (2) @(negedge g_clk);
        chk("rst_ack",   {31'd0, cpu_insn_ack},  32'd1);
        chk("rst_valid", {31'd0, cpu_rtn_valid}, 32'd0);
        chk("rst_err",   {30'd0, cpu_rtn_err},   32'd0);
        chk("rst_data",  cpu_rtn_data,           32'd0);
        chk("rst_enc",   id_encoded,             32'd0);
        chk("rst_iv",    {25'd0, fu_ivalid},     32'd0);
        g_resetn = 1'b1; chk_en = 1'b1;
        @(negedge g_clk);

        // Packed-arith, FU finishes after one cycle, no GPR write.
        run_txn(3'd1, 1'b0, 5'd0, 1, 1'b0, 32'h0, 0, 1'b0, 1'b0, 1'b0);
        chk("t1_latency", first_v, 32'd3);
        chk("t1_iv_cycles", iv_cnt, 32'd1);
        chk("t1_err", {30'd0, cap_err}, 32'd0);
        chk("t1_wen", {31'd0, cap_wen}, 32'd0);

        // mv2gpr with data, response held four cycles before ack.
        run_txn(3'd5, 1'b0, 5'd5, 2, 1'b1, 32'hDEADBEEF, 4, 1'b0, 1'b0, 1'b0);
        chk("t2_rd", {27'd0, cap_rd}, 32'd5);
        chk("t2_data", cap_data, 32'hDEADBEEF);
        chk("t2_wen", {31'd0, cap_wen}, 32'd1);

        // Decoder exception, then class 0: both illegal, nothing issued.
        run_txn(3'd3, 1'b1, 5'd7, 0, 1'b0, 32'h0, 1, 1'b0, 1'b0, 1'b0);
        chk("t3_latency", first_v, 32'd2);
        chk("t3_iv_cycles", iv_cnt, 32'd0);
        chk("t3_err", {30'd0, cap_err}, 32'd1);
        run_txn(3'd0, 1'b0, 5'd2, 0, 1'b0, 32'h0, 0, 1'b0, 1'b0, 1'b0);
        chk("t3b_err", {30'd0, cap_err}, 32'd1);

        // Hung FU with a wrong-lane done pulse: timeout after 8 issue cycles.
        run_txn(3'd4, 1'b0, 5'd9, 0, 1'b1, 32'h55AA55AA, 0, 1'b0, 1'b0, 1'b1);
        chk("t4_iv_cycles", iv_cnt, 32'd8);
        chk("t4_err", {30'd0, cap_err}, 32'd2);
        chk("t4_latency", first_v, 32'd10);

        // Done on the very last allowed cycle wins over the timeout.
        run_txn(3'd6, 1'b0, 5'd17, 8, 1'b1, 32'h12345678, 0, 1'b0, 1'b0, 1'b0);
        chk("t5_iv_cycles", iv_cnt, 32'd8);
        chk("t5_err", {30'd0, cap_err}, 32'd0);
        chk("t5_data", cap_data, 32'h12345678);

        // Done one cycle too late: timeout already taken.
        run_txn(3'd7, 1'b0, 5'd31, 9, 1'b1, 32'hCAFEF00D, 0, 1'b0, 1'b0, 1'b0);
        chk("t6_err", {30'd0, cap_err}, 32'd2);

        // No GPR write with junk data; stray requests while busy are ignored.
        run_txn(3'd2, 1'b0, 5'd12, 3, 1'b0, 32'hFFFFFFFF, 2, 1'b0, 1'b1, 1'b0);
        chk("t7_data", cap_data, 32'd0);

        // Back-to-back with rtn_ack held high.
        run_txn(3'd2, 1'b0, 5'd3, 1, 1'b1, 32'h0000_0011, 0, 1'b1, 1'b0, 1'b0);
        run_txn(3'd1, 1'b0, 5'd4, 2, 1'b1, 32'h0000_0022, 0, 1'b1, 1'b0, 1'b0);
        chk("t8_data", cap_data, 32'h0000_0022);

        // Reset while the FU is running: immediate return to idle, no response.
        start_txn(3'd4, 1'b0, 5'd8, 0, 1'b0, 32'h0, 0, 1'b0);
        for (int k = 0; k < 20 && n < 4; k++) begin
            @(negedge g_clk);
            cpu_insn_req = 1'b0;
        end
        chk("t9_pre_iv", {25'd0, fu_ivalid}, 32'h08);
        g_resetn = 1'b0;
        #1;
        t_active = 1'b0;
        chk("t9_iv", {25'd0, fu_ivalid}, 32'd0);
        chk("t9_ack", {31'd0, cpu_insn_ack}, 32'd1);
        chk("t9_valid", {31'd0, cpu_rtn_valid}, 32'd0);
        repeat (2) @(negedge g_clk);
        g_resetn = 1'b1;
        repeat (12) @(negedge g_clk);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
